// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with a valid/ready handshake on each side.
module riscv_muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter bit          FAST_MUL   = 1'b0,
  parameter bit          EARLY_DIV0 = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [CW-1:0]     r_cnt;
  logic              r_neg;
  logic              r_div0;
  logic              r_valid;
  logic [XLEN-1:0]   r_result;

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_sa;
  logic              w_sb;
  logic              w_neg;
  logic              w_is_div;
  logic              w_b_zero;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [2*XLEN-1:0] w_fprod;
  logic [XLEN:0]     w_add;
  logic [XLEN-1:0]   w_mhi;
  logic [XLEN-1:0]   w_mlo;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [XLEN-1:0]   w_dhi;
  logic [XLEN-1:0]   w_dlo;
  logic [XLEN-1:0]   w_fin;

  assign ready_o  = (r_state == S_IDLE);
  assign busy_o   = (r_state != S_IDLE);
  assign valid_o  = r_valid;
  assign result_o = r_result;

  // Apply the product sign and pick the low or high half.
  function automatic logic [XLEN-1:0] f_mul_sel(input logic [2:0] op,
                                                input logic [2*XLEN-1:0] prod,
                                                input logic neg);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Operand signedness and magnitudes at accept.
  always_comb begin
    w_a_signed = ~((op_i == OP_MULHU) | (op_i == OP_DIVU) | (op_i == OP_REMU));
    w_b_signed = w_a_signed & (op_i != OP_MULHSU);
    w_sa       = w_a_signed & a_i[XLEN-1];
    w_sb       = w_b_signed & b_i[XLEN-1];
    w_a_mag    = w_sa ? -a_i : a_i;
    w_b_mag    = w_sb ? -b_i : b_i;
    w_is_div   = op_i[2];
    w_b_zero   = (b_i == '0);
    // Remainder follows the dividend sign; product and quotient follow the XOR.
    w_neg      = (op_i[2] & op_i[1]) ? w_sa : (w_sa ^ w_sb);
    w_fprod    = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
  end

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    w_mhi   = w_add[XLEN:1];
    w_mlo   = {w_add[0], r_lo[XLEN-1:1]};
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, r_opnd});
    w_sub   = w_shift[XLEN-1:0] - r_opnd;
    w_dhi   = w_ge ? w_sub : w_shift[XLEN-1:0];
    w_dlo   = {r_lo[XLEN-2:0], w_ge};
  end

  // Result of the final iteration, including divide-by-zero values.
  always_comb begin
    w_fin = '0;
    if (!r_op[2]) begin
      w_fin = f_mul_sel(r_op, {w_mhi, w_mlo}, r_neg);
    end else if (r_div0) begin
      w_fin = r_op[1] ? r_a : '1;
    end else if (r_op[1]) begin
      w_fin = r_neg ? -w_dhi : w_dhi;
    end else begin
      w_fin = r_neg ? -w_dlo : w_dlo;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_div0   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (valid_i && !flush_i) begin
            r_op   <= op_i;
            r_a    <= a_i;
            r_neg  <= w_neg;
            r_div0 <= w_is_div & w_b_zero;
            r_cnt  <= CW'(XLEN - 1);
            r_hi   <= '0;
            r_opnd <= w_is_div ? w_b_mag : w_a_mag;
            r_lo   <= w_is_div ? w_a_mag : w_b_mag;
            if (FAST_MUL && !w_is_div) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_result <= f_mul_sel(op_i, w_fprod, w_neg);
            end else if (EARLY_DIV0 && w_is_div && w_b_zero) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_result <= op_i[1] ? a_i : '1;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end else begin
            r_hi  <= r_op[2] ? w_dhi : w_mhi;
            r_lo  <= r_op[2] ? w_dlo : w_mlo;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_result <= w_fin;
            end
          end
        end
        S_DONE: begin
          if (flush_i || ready_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: one 32-bit iterative instance and one
// 64-bit FAST_MUL instance, checked against hand-computed expected results.
module tb_riscv_muldiv_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        v0, f0, r0i, ro0, vo0, busy0;
  logic [2:0]  op0;
  logic [31:0] a0, b0, res0;

  logic        v1, f1, r1i, ro1, vo1, busy1;
  logic [2:0]  op1;
  logic [63:0] a1, b1, res1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp0[$];
  logic [63:0] exp1[$];
  logic [31:0] m0_exp;
  logic [63:0] m1_exp;

  always #5 clk = ~clk;

  riscv_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0), .EARLY_DIV0(1'b1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v0), .ready_o(ro0), .op_i(op0),
    .a_i(a0), .b_i(b0), .flush_i(f0), .valid_o(vo0), .ready_i(r0i),
    .result_o(res0), .busy_o(busy0)
  );

  riscv_muldiv_unit #(.XLEN(64), .FAST_MUL(1'b1), .EARLY_DIV0(1'b0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v1), .ready_o(ro1), .op_i(op1),
    .a_i(a1), .b_i(b1), .flush_i(f1), .valid_o(vo1), .ready_i(r1i),
    .result_o(res1), .busy_o(busy1)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitors: pop and compare whenever a result is handed over.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && vo0 === 1'b1 && r0i === 1'b1) begin
      if (exp0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL result0: got %h with no result expected", res0);
      end else begin
        m0_exp = exp0.pop_front();
        check("result0", 64'(res0), 64'(m0_exp));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && vo1 === 1'b1 && r1i === 1'b1) begin
      if (exp1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL result1: got %h with no result expected", res1);
      end else begin
        m1_exp = exp1.pop_front();
        check("result1", res1, m1_exp);
      end
    end
  end

  task automatic accept_only(input int d, input logic [2:0] op, input logic [63:0] a,
                             input logic [63:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (((d == 0) ? ro0 : ro1) !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: ready_o low for %0d cycles, required 1", guard);
    end
    if (d == 0) begin
      v0 = 1'b1; op0 = op; a0 = a[31:0]; b0 = b[31:0];
    end else begin
      v1 = 1'b1; op1 = op; a1 = a; b1 = b;
    end
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    op0 = 3'($urandom); a0 = $urandom; b0 = $urandom;
    op1 = 3'($urandom); a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
  endtask

  task automatic issue(input int d, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    if (d == 0) exp0.push_back(exp[31:0]);
    else        exp1.push_back(exp);
    accept_only(d, op, a, b);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (((d == 0) ? vo0 : vo1) !== 1'b1 && lat < 200);
    check("latency", 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit stable;
    bit seen;
    rst_n = 1'b0;
    v0 = 1'b0; f0 = 1'b0; r0i = 1'b1; op0 = '0; a0 = '0; b0 = '0;
    v1 = 1'b0; f1 = 1'b0; r1i = 1'b1; op1 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready0", 64'(ro0), 64'd1);
    check("rst_valid0", 64'(vo0), 64'd0);
    check("rst_result0", 64'(res0), 64'd0);
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_ready1", 64'(ro1), 64'd1);
    check("rst_result1", res1, 64'd0);

    // Multiply family, XLEN=32 iterative.
    issue(0, OP_MUL,    64'd7,          64'hFFFFFFFD, 64'hFFFFFFEB, 33);
    issue(0, OP_MULH,   64'h80000000,   64'h80000000, 64'h40000000, 33);
    issue(0, OP_MULHU,  64'h80000000,   64'h80000000, 64'h40000000, 33);
    issue(0, OP_MULHSU, 64'hFFFFFFFF,   64'hFFFFFFFF, 64'hFFFFFFFF, 33);

    // Divide family, overflow and divide-by-zero.
    issue(0, OP_DIV,  64'hFFFFFFEC, 64'd3,        64'hFFFFFFFA, 33);
    issue(0, OP_REM,  64'hFFFFFFEC, 64'd3,        64'hFFFFFFFE, 33);
    issue(0, OP_DIVU, 64'd20,       64'd3,        64'd6,        33);
    issue(0, OP_DIV,  64'h80000000, 64'hFFFFFFFF, 64'h80000000, 33);
    issue(0, OP_REM,  64'h80000000, 64'hFFFFFFFF, 64'd0,        33);
    issue(0, OP_DIVU, 64'd5,        64'd0,        64'hFFFFFFFF, 1);
    issue(0, OP_REMU, 64'd5,        64'd0,        64'd5,        1);
    issue(0, OP_DIV,  64'hFFFFFFF9, 64'd0,        64'hFFFFFFFF, 1);
    issue(0, OP_REM,  64'hFFFFFFF9, 64'd0,        64'hFFFFFFF9, 1);

    // Back-pressure: hold in DONE and ignore a request pulse.
    @(posedge clk); #1; r0i = 1'b0;
    issue(0, OP_MULHU, 64'h80000000, 64'h80000000, 64'h40000000, 33);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      v0 = (i == 4); op0 = OP_MUL; a0 = 32'd1; b0 = 32'd1;
      @(negedge clk);
      if (vo0 !== 1'b1 || res0 !== 32'h40000000 || ro0 !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'd1);
    @(posedge clk); #1; r0i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    check("hold_release_idle", 64'(busy0), 64'd0);

    // Flush in CALC cycle 5.
    accept_only(0, OP_MUL, 64'd3, 64'd5);
    repeat (4) @(posedge clk);
    @(negedge clk); f0 = 1'b1;
    @(posedge clk); #1; f0 = 1'b0;
    check("flush_busy", 64'(busy0), 64'd0);
    check("flush_ready", 64'(ro0), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (vo0 === 1'b1) seen = 1'b1;
    end
    check("flush_no_valid", 64'(seen), 64'd0);

    // Flush beats a request in IDLE.
    @(negedge clk); v0 = 1'b1; f0 = 1'b1; op0 = OP_MUL; a0 = 32'd2; b0 = 32'd2;
    @(posedge clk); #1; v0 = 1'b0; f0 = 1'b0;
    check("idle_flush_prio", 64'(busy0), 64'd0);

    // Asynchronous reset in the middle of CALC.
    accept_only(0, OP_DIVU, 64'd100, 64'd7);
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(ro0), 64'd1);
    check("arst_valid", 64'(vo0), 64'd0);
    check("arst_busy", 64'(busy0), 64'd0);
    check("arst_result", 64'(res0), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Back-to-back with a single idle bubble.
    issue(0, OP_DIVU, 64'd100, 64'd7, 64'd14, 33);
    check("b2b_no_accept_in_done", 64'(ro0), 64'd0);
    @(posedge clk); #1;
    check("b2b_bubble_ready", 64'(ro0), 64'd1);
    issue(0, OP_MUL, 64'd6, 64'd7, 64'd42, 33);

    // XLEN=64, FAST_MUL=1, EARLY_DIV0=0.
    issue(1, OP_MUL, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 1);
    issue(1, OP_DIVU, 64'd1000, 64'd10, 64'd100, 65);
    @(posedge clk); #1;
    check("b2b64_bubble_ready", 64'(ro1), 64'd1);
    issue(1, OP_MUL, 64'd123456789, 64'd1000, 64'd123456789000, 1);
    issue(1, OP_MULHU,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 1);
    issue(1, OP_MULH,   64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1);
    issue(1, OP_MULHSU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1);
    issue(1, OP_DIVU, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 65);
    issue(1, OP_REM,  64'hFFFFFFFFFFFFFFF9, 64'd0, 64'hFFFFFFFFFFFFFFF9, 65);
    issue(1, OP_DIV,  64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 65);

    repeat (5) @(negedge clk);
    check("queue0_drained", 64'(exp0.size()), 64'd0);
    check("queue1_drained", 64'(exp1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
